// File: rtl/led_matrix_bcm_driver.sv
// HUB75 panel timing engine: row scanning, binary-code-modulation bit planes and
// global brightness. Display of the latched plane overlaps shifting of the next one.
module led_matrix_bcm_driver #(
   parameter int PANEL_COLS     = 64,
   parameter int SCAN_ROWS      = 32,
   parameter int COLOR_BITS     = 8,
   parameter int BASE_OE_CYCLES = 4,
   parameter int BLANK_CYCLES   = 2,
   localparam int COL_W   = $clog2(PANEL_COLS),
   localparam int ROW_W   = $clog2(SCAN_ROWS),
   localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prescaler_enable,
   input  logic               prescaler_bypass,
   input  logic [7:0]         brightness,
   output logic [COL_W-1:0]   frame_column,
   output logic [ROW_W-1:0]   frame_row,
   output logic [PLANE_W-1:0] bit_plane,
   output logic               line_sync,
   output logic               frame_sync,
   output logic               matrix_clk,
   output logic               matrix_stb,
   output logic               matrix_oe_n,
   output logic [ROW_W-1:0]   matrix_addr
);
   localparam int CNT_W  = $clog2(BASE_OE_CYCLES << COLOR_BITS);
   localparam int BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int PROD_W = CNT_W + 9;

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_WAIT, S_BLANK, S_LATCH, S_ADDR
   } state_t;

   state_t             r_state;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [PLANE_W-1:0] r_plane;
   logic [PLANE_W-1:0] r_disp_plane;
   logic [ROW_W-1:0]   r_addr;
   logic [CNT_W-1:0]   r_cnt;
   logic [BLK_W-1:0]   r_blank;
   logic [7:0]         r_bright;
   logic               r_disp_valid;
   logic               r_toggle;

   logic               w_tick;
   logic               w_col_step;
   logic               w_col_last;
   logic               w_row_last;
   logic               w_plane_last;
   logic               w_blank_last;
   logic               w_cnt_expiring;
   logic [CNT_W-1:0]   w_on;
   logic [CNT_W-1:0]   w_elapsed;
   logic [8:0]         w_bright_p1;
   logic [PROD_W-1:0]  w_thr;

   assign w_tick         = prescaler_enable | prescaler_bypass;
   assign w_col_step     = prescaler_bypass | r_toggle;
   assign w_col_last     = (r_col == COL_W'(PANEL_COLS - 1));
   assign w_row_last     = (r_row == ROW_W'(SCAN_ROWS - 1));
   assign w_plane_last   = (r_plane == PLANE_W'(COLOR_BITS - 1));
   assign w_blank_last   = (r_blank == BLK_W'(BLANK_CYCLES - 1));
   // Expiring means the counter reaches zero on this tick (or already sits there).
   assign w_cnt_expiring = (r_cnt <= CNT_W'(1));
   assign w_on           = CNT_W'(BASE_OE_CYCLES) << r_disp_plane;
   assign w_elapsed      = w_on - r_cnt;
   assign w_bright_p1    = {1'b0, r_bright} + 9'd1;
   assign w_thr          = (PROD_W'(w_on) * PROD_W'(w_bright_p1)) >> 4'd8;

   assign frame_column = r_col;
   assign frame_row    = r_row;
   assign bit_plane    = r_plane;
   assign matrix_addr  = r_addr;

   // Sequencer: all motion is gated by the tick strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_plane      <= '0;
         r_disp_plane <= '0;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_blank      <= '0;
         r_bright     <= 8'd0;
         r_disp_valid <= 1'b0;
         r_toggle     <= 1'b0;
      end else if (w_tick) begin
         case (r_state)
            S_IDLE: begin
               r_toggle <= 1'b0;
               r_state  <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
               if (!prescaler_bypass) r_toggle <= ~r_toggle;
               if (w_col_step) begin
                  if (w_col_last) begin
                     r_col   <= '0;
                     r_state <= w_cnt_expiring ? S_BLANK : S_WAIT;
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
               if (w_cnt_expiring) r_state <= S_BLANK;
            end
            S_BLANK: begin
               if (w_blank_last) begin
                  r_blank <= '0;
                  r_state <= S_LATCH;
               end else begin
                  r_blank <= r_blank + BLK_W'(1);
               end
            end
            S_LATCH: begin
               r_col        <= '0;
               r_disp_valid <= 1'b1;
               r_bright     <= brightness;
               r_disp_plane <= r_plane;
               r_addr       <= r_row;
               r_state      <= S_ADDR;
               // Plane advances first; the row steps when the plane wraps.
               if (w_plane_last) begin
                  r_plane <= '0;
                  r_row   <= w_row_last ? '0 : r_row + ROW_W'(1);
               end else begin
                  r_plane <= r_plane + PLANE_W'(1);
               end
            end
            S_ADDR: begin
               if (w_blank_last) begin
                  r_blank  <= '0;
                  r_cnt    <= w_on;
                  r_toggle <= 1'b0;
                  r_state  <= S_SHIFT;
               end else begin
                  r_blank <= r_blank + BLK_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Panel strobes decoded from the sequencer registers.
   always_comb begin
      matrix_stb = (r_state == S_LATCH);
      if (prescaler_bypass) begin
         matrix_clk = (r_state == S_SHIFT) & ~clk;
      end else begin
         matrix_clk = (r_state == S_SHIFT) & r_toggle;
      end
      if (((r_state == S_SHIFT) || (r_state == S_WAIT)) && r_disp_valid &&
          (PROD_W'(w_elapsed) < w_thr)) begin
         matrix_oe_n = 1'b0;
      end else begin
         matrix_oe_n = 1'b1;
      end
      line_sync  = ~rst & w_tick & (r_state == S_ADDR) & w_blank_last;
      frame_sync = ~rst & w_tick & (r_state == S_LATCH) & w_row_last & w_plane_last;
   end
endmodule

// File: doc/led_matrix_bcm_driver.md
Name: led_matrix_bcm_driver

Overview:
- Next-generation HUB75 panel timing engine. Adds row scanning, binary-code-modulation (BCM) bit planes and global brightness to the column-shift/latch/OE sequencing.
- Sits between the prescaler and the framebuffer reader.
- Requests pixel data by (row, bit plane, column) and drives panel clk/stb/oe_n/address.
- Display of the latched plane overlaps with shifting of the next plane.

Parameters:
- PANEL_COLS, 64, columns shifted per plane (>=2)
- SCAN_ROWS, 32, multiplexed row addresses (>=2, power of 2)
- COLOR_BITS, 8, bit planes per row (>=1)
- BASE_OE_CYCLES, 4, display ticks for plane 0; plane p gets BASE_OE_CYCLES<<p
- BLANK_CYCLES, 2, ticks spent in BLANK and in ADDR each (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- prescaler_enable  in  1  tick strobe
- prescaler_bypass  in  1  every clk is a tick; matrix_clk = !clk while shifting
- brightness  in  8  global dimming, sampled at each LATCH
- frame_column  out  $clog2(PANEL_COLS)  column currently being shifted
- frame_row  out  $clog2(SCAN_ROWS)  row currently being shifted
- bit_plane  out  $clog2(COLOR_BITS) (min 1)  plane currently being shifted
- line_sync  out  1  one-clk pulse on the last clk of ADDR
- frame_sync  out  1  one-clk pulse at the LATCH of row SCAN_ROWS-1, plane COLOR_BITS-1
- matrix_clk  out  1  panel shift clock
- matrix_stb  out  1  panel latch
- matrix_oe_n  out  1  panel output enable, active low
- matrix_addr  out  $clog2(SCAN_ROWS)  displayed row address

Behaviour:
- Tick = enable = prescaler_enable | prescaler_bypass. State advances and counters move only on ticks.
- Synchronous rst, effective at any point including mid-shift:
  - state IDLE; column, row, plane, matrix_addr = 0.
  - Display counter = 0; disp_valid = 0; clock_toggle = 0.
  - Outputs: matrix_oe_n = 1, matrix_stb = 0, matrix_clk = 0, line_sync = 0, frame_sync = 0.
- States: IDLE -> SHIFT -> (WAIT) -> BLANK -> LATCH -> ADDR -> SHIFT.
  - IDLE: one tick, then SHIFT.
  - SHIFT:
    - Bypass: column increments every tick.
    - Otherwise: clock_toggle flips each tick; column increments on ticks where toggle = 1.
    - matrix_clk = clock_toggle in SHIFT (bypass: !clk in SHIFT).
    - Shift ends on the tick where column == PANEL_COLS-1 increments.
    - Next state is BLANK if the display counter has expired, else WAIT.
  - WAIT: hold; go to BLANK on the tick the display counter expires.
  - BLANK: OE high for BLANK_CYCLES ticks, then LATCH.
  - LATCH:
    - One tick; matrix_stb = 1 for that whole state.
    - column clears; disp_valid set; brightness sampled.
    - Displayed (row, plane) = shifted (row, plane).
    - Shift pointer advances plane first: plane wraps at COLOR_BITS-1 and row increments; row wraps at SCAN_ROWS-1 to 0.
  - ADDR:
    - matrix_addr <= displayed row on entry.
    - OE high for BLANK_CYCLES ticks.
    - Display counter loads on = BASE_OE_CYCLES<<displayed_plane on exit.
- Display counter:
  - Decrements each tick in SHIFT/WAIT while nonzero; expired = 0.
  - Width $clog2(BASE_OE_CYCLES<<COLOR_BITS).
- matrix_oe_n = 0 only when all hold:
  - state is SHIFT or WAIT;
  - disp_valid = 1;
  - elapsed = on - counter < thr, where thr = (on*(brightness+1))>>8, full-width product with no truncation before the shift.
  - brightness 255 gives full on-time; brightness 0 gives on>>8 (typically 0, always dark).
- First plane after reset: disp_valid = 0, so OE stays high and the counter is 0; SHIFT goes straight to BLANK.
- Pulse timing:
  - line_sync: one clk, on the final ADDR tick.
  - frame_sync: one clk, coincident with the qualifying LATCH tick.
- Enable low in any state: full hold, no counter motion; matrix_clk is held at its current toggle level and forced 0 in bypass.
- prescaler_bypass is static between resets; changing it mid-operation is undefined.

Test Plan:
- Common params: PANEL_COLS=4, SCAN_ROWS=2, COLOR_BITS=3, BASE_OE_CYCLES=2, BLANK_CYCLES=1, bypass=1, brightness=255.
- Reset:
  - Assert rst for 3 clk mid-SHIFT, then release.
  - Check oe_n=1, stb=0, clk=0, addr=0, frame_column=0.
  - IDLE lasts 1 clk, then 4 matrix_clk pulses.
- Sequencing:
  - Shifted (row,plane) order is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - One stb pulse per shift; frame_sync on the 6th LATCH only; matrix_addr follows the latched row.
- BCM widths:
  - OE-low run lengths per displayed plane are 2, 4, 8 clk.
  - The plane-2 display forces 4 clk of WAIT after the 4-clk shift.
  - No OE before the first LATCH.
- Brightness:
  - brightness=127 gives OE runs of 1, 2, 4.
  - brightness=0 keeps matrix_oe_n constantly 1.
- Prescaler mode:
  - bypass=0, prescaler_enable every 3rd clk.
  - One shift takes 8 ticks (24 clk) with 4 matrix_clk highs each lasting 3 clk.
  - All counters freeze between ticks.
